// File: rtl/vs_tx_fifo_if.sv
// Producer/UART-side bundle for vs_tx_fifo.
// Carries the hwm output when VS_TX_FIFO_HIGH_WATER_EN is defined.
interface vs_tx_fifo_if #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [DATA_W-1:0]     wr_data;
    logic                  flush;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  ovf;
    logic                  tx_start;
    logic [DATA_W-1:0]     tx_data;
    logic                  tx_busy;
`ifdef VS_TX_FIFO_HIGH_WATER_EN
    logic [DEPTH_LOG2:0]   hwm;

    modport master (
        output wr_en, wr_data, flush, tx_busy,
        input  full, empty, level, ovf, tx_start, tx_data, hwm
    );
    modport slave (
        input  wr_en, wr_data, flush, tx_busy,
        output full, empty, level, ovf, tx_start, tx_data, hwm
    );
`else
    modport master (
        output wr_en, wr_data, flush, tx_busy,
        input  full, empty, level, ovf, tx_start, tx_data
    );
    modport slave (
        input  wr_en, wr_data, flush, tx_busy,
        output full, empty, level, ovf, tx_start, tx_data
    );
`endif
endinterface

// File: rtl/vs_tx_fifo.sv
// Byte FIFO between protocol FSM and UART TX with a self-draining start/busy handshake.
// Optional high-water mark output enabled by VS_TX_FIFO_HIGH_WATER_EN.
module vs_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ACK_TMO    = 8
) (
    input  logic          clk,
    input  logic          sys_nrst,
    vs_tx_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned TMR_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    ovf_q;
    logic                    tx_start_q;
    logic [DATA_W-1:0]       tx_data_q;
    logic                    full_c, empty_c, wr_acc_c, pop_c;

    assign full_c   = (level_q == LVL_W'(DEPTH));
    assign empty_c  = (level_q == '0);
    // Flush wins over a same-cycle write; a pop never frees room for a write while full.
    assign wr_acc_c = bus.wr_en & ~full_c & ~bus.flush;

    // Drain FSM next-state
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty_c && !bus.tx_busy && !bus.flush) begin
                    pop_c   = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_ACK;
                tmr_d   = '0;
            end
            S_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == TMR_W'(ACK_TMO - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (bus.flush) begin
            level_d = '0;
        end else if (wr_acc_c && !pop_c) begin
            level_d = level_q + LVL_W'(1);
        end else if (!wr_acc_c && pop_c) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            tx_start_q <= (state_d == S_START);
            if (pop_c) begin
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                ovf_q    <= 1'b0;
            end else begin
                if (wr_acc_c) begin
                    wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
                end
                if (bus.wr_en && full_c) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem[wr_ptr_q] <= bus.wr_data;
        end
    end

`ifdef VS_TX_FIFO_HIGH_WATER_EN
    logic [LVL_W-1:0] hwm_q;

    always_ff @(posedge clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            hwm_q <= '0;
        end else if (bus.flush) begin
            hwm_q <= '0;
        end else if (level_d > hwm_q) begin
            hwm_q <= level_d;
        end
    end

    assign bus.hwm = hwm_q;
`endif

    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.level    = level_q;
    assign bus.ovf      = ovf_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_vs_tx_fifo.sv
// Randomized self-checking bench for vs_tx_fifo against a queue-based reference model.
// Checks hwm as well when VS_TX_FIFO_HIGH_WATER_EN is defined.
module tb_vs_tx_fifo;
    localparam int unsigned DW    = 8;
    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TMO   = 8;

    logic clk      = 1'b0;
    logic sys_nrst = 1'b0;

    vs_tx_fifo_if #(.DATA_W(DW), .DEPTH_LOG2(DL2)) bus ();

    vs_tx_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL2), .ACK_TMO(TMO)) dut (
        .clk      (clk),
        .sys_nrst (sys_nrst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue plus the drain phase of the byte in flight.
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_ph;      // 0 idle, 1 start pulse, 2 waiting for ack, 3 waiting for done
    int         m_tmr;
    logic [7:0] m_txd;
    int         m_hwm;

    // UART responder state
    int u_wait;
    int u_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_ph   = 0;
        m_tmr  = 0;
        m_txd  = 8'h00;
        m_hwm  = 0;
        u_wait = 0;
        u_hold = 0;
    endtask

    // Advance the model across one clock edge using the inputs applied before it.
    task automatic model_edge(input bit we, input logic [7:0] wd, input bit fl, input bit busy);
        bit full_now;
        bit pop;
        full_now = (mq.size() == DEPTH);
        pop      = (m_ph == 0) && (mq.size() > 0) && !busy && !fl;
        case (m_ph)
            0: if (pop) begin
                m_txd = mq.pop_front();
                m_ph  = 1;
            end
            1: begin
                m_ph  = 2;
                m_tmr = 0;
            end
            2: begin
                if (busy) m_ph = 3;
                else if (m_tmr == TMO - 1) m_ph = 0;
                else m_tmr++;
            end
            default: if (!busy) m_ph = 0;
        endcase
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
            m_hwm = 0;
        end else begin
            if (we && full_now) m_ovf = 1'b1;
            else if (we) mq.push_back(wd);
            if (mq.size() > m_hwm) m_hwm = mq.size();
        end
    endtask

    task automatic compare_all();
        check("level", 32'(bus.level), 32'(mq.size()));
        check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
        check("empty", 32'(bus.empty), 32'(mq.size() == 0));
        check("ovf", 32'(bus.ovf), 32'(m_ovf));
        check("tx_start", 32'(bus.tx_start), 32'(m_ph == 1));
        check("tx_data", 32'(bus.tx_data), 32'(m_txd));
`ifdef VS_TX_FIFO_HIGH_WATER_EN
        check("hwm", 32'(bus.hwm), 32'(m_hwm));
`endif
    endtask

    task automatic step(input bit we, input logic [7:0] wd, input bit fl, input bit busy);
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.flush   = fl;
        bus.tx_busy = busy;
        model_edge(we, wd, fl, busy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // One cycle with a UART that acks a start pulse with probability ack_pct.
    task automatic uart_step(input bit we, input logic [7:0] wd, input bit fl, input int ack_pct);
        bit b;
        b = (u_wait == 0) && (u_hold > 0);
        step(we, wd, fl, b);
        if (u_wait > 0) u_wait--;
        else if (u_hold > 0) u_hold--;
        if (bus.tx_start && ($urandom_range(99) < ack_pct)) begin
            u_wait = $urandom_range(0, 2);
            u_hold = $urandom_range(1, 5);
        end
    endtask

    task automatic do_reset();
        sys_nrst    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.flush   = 1'b0;
        bus.tx_busy = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(negedge clk);
        sys_nrst = 1'b1;
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.flush   = 1'b0;
        bus.tx_busy = 1'b0;
        #3;
        do_reset();

        // Single byte, then UART busy for 20 cycles
        step(1'b1, 8'h41, 1'b0, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (20) step(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full while busy, overflow, then drain in order
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) uart_step(1'b0, 8'h00, 1'b0, 100);
        check("drained_level", 32'(bus.level), 32'd0);

        // UART never acks: each byte times out, no retry
        step(1'b1, 8'hA0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        repeat (30) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Overflow, drain down to 5, then flush together with a write
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        for (int i = 0; i < 300 && mq.size() > 5; i++) uart_step(1'b0, 8'h00, 1'b0, 100);
        check("pre_flush_level", 32'(bus.level), 32'd5);
        uart_step(1'b1, 8'h55, 1'b1, 100);
        check("post_flush_ovf", 32'(bus.ovf), 32'd0);
        repeat (40) uart_step(1'b0, 8'h00, 1'b0, 100);

        // Streaming at roughly UART rate, pointers wrap
        for (int i = 0; i < 40; i++) begin
            uart_step(1'b1, 8'($urandom), 1'b0, 100);
            repeat ($urandom_range(2, 5)) uart_step(1'b0, 8'h00, 1'b0, 100);
        end
        repeat (100) uart_step(1'b0, 8'h00, 1'b0, 100);

        // High-water: burst of 9 while busy, drain, then flush
        step(1'b0, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
        repeat (120) uart_step(1'b0, 8'h00, 1'b0, 100);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset while a byte is in flight
        for (int i = 0; i < 3; i++) uart_step(1'b1, 8'(8'h70 + i), 1'b0, 100);
        for (int i = 0; i < 20 && u_hold == 0; i++) uart_step(1'b0, 8'h00, 1'b0, 100);
        do_reset();
        repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with occasional flush and missing acks
        for (int i = 0; i < 2500; i++) begin
            uart_step($urandom_range(99) < 40, 8'($urandom), $urandom_range(999) < 5, 85);
        end
        repeat (200) uart_step(1'b0, 8'h00, 1'b0, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
